btn_debounce_pulse: RTL
=======================

// Module: btn_debounce_pulse
// PURPOSE
//  Conditions one raw push-button input into clean, clock-synchronous events.
//  Sits directly upstream of the image selector and drives its btn_pressed input.
//  - Synchronizes the asynchronous pin.
//  - Rejects contact bounce.
//  - Emits exactly one 1-cycle btn_pressed pulse per physical press.
//  - Also provides the debounced level and a release pulse.
// PARAMETERS
//  DEBOUNCE_CYCLES  1_000_000   consecutive stable samples required (10 ms @ 100 MHz); >=2
//  REPEAT_DELAY     50_000_000  cycles in HELD before first auto-repeat pulse (macro only)
//  REPEAT_PERIOD    20_000_000  cycles between subsequent auto-repeat pulses (macro only)
//  CNT_W            26          counter width; must hold max(all cycle params)-1
// PORTS
//  clk           in   1  system clock
//  reset         in   1  synchronous, active-high reset
//  btn_raw       in   1  raw button pin, asynchronous, active-high
//  btn_pressed   out  1  1-cycle pulse per accepted press (and per repeat, see CONFIGURATION)
//  btn_released  out  1  1-cycle pulse per accepted release
//  btn_level     out  1  debounced button level
// BEHAVIOUR
//  - Reset (sync, active-high):
//    - All outputs 0; 2-FF synchronizer 0; state IDLE; counters 0.
//    - Reset has priority over every other event.
//  - Synchronizer:
//    - sync = 2nd flop of a 2-FF chain on btn_raw.
//    - The FSM sees only sync, never btn_raw.
//  - Debounce counter cnt:
//    - Cleared on every state entry; +1 per cycle otherwise.
//    - Never wraps: it is cleared before reaching DEBOUNCE_CYCLES.
//  - FSM states:
//    - IDLE: sync=1 -> PRESS_WAIT.
//    - PRESS_WAIT:
//      - sync=0 -> IDLE; bounce rejected, no output.
//      - cnt==DEBOUNCE_CYCLES-1 with sync=1 -> HELD; registered btn_pressed=1 for one cycle; btn_level<=1.
//    - HELD: sync=0 -> RELEASE_WAIT.
//    - RELEASE_WAIT:
//      - sync=1 -> HELD; glitch, no new btn_pressed.
//      - cnt==DEBOUNCE_CYCLES-1 with sync=0 -> IDLE; btn_released=1 for one cycle; btn_level<=0.
//  - Latency:
//    - Edge 0 is the first clock edge that samples btn_raw=1, and btn_raw stays high.
//    - btn_pressed is registered at edge DEBOUNCE_CYCLES+2 and is high for exactly that one cycle.
//    - Release is symmetric: btn_released is registered at edge DEBOUNCE_CYCLES+2 after btn_raw falls.
//  - Invariants:
//    - btn_pressed and btn_released are never high in the same cycle.
//    - Pulses are never wider than 1 cycle.
//  - Boundaries:
//    - Reset mid-PRESS_WAIT: no pulse is issued. A button still held after reset is treated as a new press after a full debounce.
//    - Reset while HELD: btn_level drops to 0 immediately; no btn_released pulse.
//    - A bounce on the final counting cycle (cnt==DEBOUNCE_CYCLES-1 with sync flipped) is rejected.
// CONFIGURATION
//  BTN_AUTOREPEAT_EN defined:
//   - A repeat counter runs while in HELD. It holds its value in RELEASE_WAIT and is cleared on entry to IDLE and on reset.
//   - First extra btn_pressed pulse after REPEAT_DELAY cycles in HELD.
//   - Then one pulse every REPEAT_PERIOD cycles until the button leaves HELD.
//  BTN_AUTOREPEAT_EN undefined:
//   - No repeat counter is synthesized.
//   - Exactly one btn_pressed pulse per press, however long the button is held.
// TESTING (bench params: DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=5)
//  1 Clean press: btn_raw 0->1 at edge 0, held 20 cycles -> single btn_pressed at edge 6; btn_level=1 from edge 6.
//  2 Bounce: btn_raw toggles 2 cycles high / 1 cycle low for 30 cycles, then 0 -> no btn_pressed, no btn_released, btn_level stays 0.
//  3 Bouncy release: from HELD, btn_raw 1->0 with a 1-cycle high glitch -> exactly one btn_released after 4 stable low samples; no btn_pressed.
//  4 Reset mid-PRESS_WAIT (cnt=2) with btn_raw held high -> all outputs 0 during reset; one btn_pressed at edge 6 counted from the reset release.
//  5 Hold 40 cycles, macro on -> pulses at HELD entry, +10, +15, +20, ... ; macro off -> only the HELD-entry pulse.
//  6 Integration with the image selector: 4 clean presses -> image_select steps 0->1->2->3->0; bounce-only input leaves it at 0.

Source files
------------

// File: rtl/btn_debounce_pulse.sv
// Push-button conditioner: 2-FF synchronizer, debounce FSM, press/release pulses and level.
// Define BTN_AUTOREPEAT_EN to add auto-repeat btn_pressed pulses while the button is held.
module btn_debounce_pulse #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int REPEAT_DELAY    = 50_000_000,
  parameter int REPEAT_PERIOD   = 20_000_000,
  parameter int CNT_W           = 26
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic btn_pressed,
  output logic btn_released,
  output logic btn_level
);

  typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT} state_t;

  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Reject configurations the counters cannot represent.
  if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1 ||
      DEBOUNCE_CYCLES - 1 >= 2**CNT_W || REPEAT_DELAY - 1 >= 2**CNT_W ||
      REPEAT_PERIOD - 1 >= 2**CNT_W) begin : g_bad_param
    $error("btn_debounce_pulse: invalid parameter set");
  end

  logic             sync_ff1_reg, sync_reg;
  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             pressed_reg, pressed_next, press_edge;
  logic             released_reg, released_next;
  logic             level_reg, level_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_ff1_reg <= 1'b0;
      sync_reg     <= 1'b0;
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      pressed_reg  <= 1'b0;
      released_reg <= 1'b0;
      level_reg    <= 1'b0;
    end else begin
      sync_ff1_reg <= btn_raw;
      sync_reg     <= sync_ff1_reg;
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      pressed_reg  <= pressed_next;
      released_reg <= released_next;
      level_reg    <= level_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    cnt_next      = '0;
    press_edge    = 1'b0;
    released_next = 1'b0;
    level_next    = level_reg;
    unique case (state_reg)
      IDLE: begin
        if (sync_reg) state_next = PRESS_WAIT;
      end
      PRESS_WAIT: begin
        if (!sync_reg) begin
          state_next = IDLE;
        end else if (cnt_reg == DB_LAST) begin
          state_next = HELD;
          press_edge = 1'b1;
          level_next = 1'b1;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      HELD: begin
        if (!sync_reg) state_next = RELEASE_WAIT;
      end
      RELEASE_WAIT: begin
        if (sync_reg) begin
          state_next = HELD;
        end else if (cnt_reg == DB_LAST) begin
          state_next    = IDLE;
          released_next = 1'b1;
          level_next    = 1'b0;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

`ifdef BTN_AUTOREPEAT_EN
  localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RP_LAST = CNT_W'(REPEAT_PERIOD - 1);

  // rep_first_reg selects the initial delay until the first repeat has fired.
  logic [CNT_W-1:0] rep_cnt_reg, rep_cnt_next;
  logic             rep_first_reg, rep_first_next;
  logic             rep_fire;

  always_ff @(posedge clk) begin
    if (reset) begin
      rep_cnt_reg   <= '0;
      rep_first_reg <= 1'b1;
    end else begin
      rep_cnt_reg   <= rep_cnt_next;
      rep_first_reg <= rep_first_next;
    end
  end

  always_comb begin
    rep_cnt_next   = rep_cnt_reg;
    rep_first_next = rep_first_reg;
    rep_fire       = 1'b0;
    if (state_next == IDLE) begin
      rep_cnt_next   = '0;
      rep_first_next = 1'b1;
    end else if (state_reg == HELD && sync_reg) begin
      if (rep_cnt_reg == (rep_first_reg ? RD_LAST : RP_LAST)) begin
        rep_fire       = 1'b1;
        rep_cnt_next   = '0;
        rep_first_next = 1'b0;
      end else begin
        rep_cnt_next = rep_cnt_reg + 1'b1;
      end
    end
  end

  assign pressed_next = press_edge | rep_fire;
`else
  assign pressed_next = press_edge;
`endif

  assign btn_pressed  = pressed_reg;
  assign btn_released = released_reg;
  assign btn_level    = level_reg;

endmodule
